// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one byte-wide memory port,
// big-endian, with data priority and a one-deep anti-starvation flag for fetch.
module mem_port_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_data,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              PCWrite,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;
   state_t            state_q;
   logic [1:0]        cnt_q;
   logic              data_q, we_q, word_q, fav_q;
   logic [ADDR_W-1:0] base_q, mem_addr_q;
   logic [31:0]       wdata_q, asm_q, if_data_q, d_rdata_q;
   logic [7:0]        mem_wdata_q;
   logic              mem_en_q, mem_we_q, if_done_q, d_done_q, busy_q;
   logic              gnt_data_d, last_d;
   logic [1:0]        cnt_d;
   logic [31:0]       asm_d;

   function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] k, input logic word);
      return word ? w[{~k, 3'b000} +: 8] : w[7:0];
   endfunction

   // fav_q records that the last completed grant was data, so a waiting fetch goes next
   assign gnt_data_d = d_req && !(fav_q && if_req);
   assign cnt_d      = cnt_q + 2'd1;
   assign last_d     = !word_q || cnt_q == 2'd3;
   assign asm_d      = word_q ? {asm_q[23:0], mem_rdata} : {24'h0, mem_rdata};

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= 1'b0;
         we_q        <= 1'b0;
         word_q      <= 1'b0;
         fav_q       <= 1'b0;
         base_q      <= '0;
         wdata_q     <= '0;
         asm_q       <= '0;
         if_data_q   <= '0;
         d_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (d_req || if_req) begin
               state_q     <= BEAT;
               cnt_q       <= '0;
               data_q      <= gnt_data_d;
               we_q        <= gnt_data_d && d_we;
               word_q      <= !gnt_data_d || d_size;
               base_q      <= gnt_data_d ? d_addr : if_addr;
               wdata_q     <= d_wdata;
               fav_q       <= fav_q && gnt_data_d;
               mem_en_q    <= 1'b1;
               mem_we_q    <= gnt_data_d && d_we;
               mem_addr_q  <= gnt_data_d ? d_addr : if_addr;
               mem_wdata_q <= (gnt_data_d && d_we) ? pick(d_wdata, 2'd0, d_size) : 8'h00;
               busy_q      <= 1'b1;
            end
            BEAT: begin
               asm_q <= asm_d;
               if (last_d) begin
                  state_q     <= RESP;
                  mem_en_q    <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  if_done_q   <= !data_q;
                  d_done_q    <= data_q;
                  fav_q       <= data_q;
                  if (!data_q) if_data_q <= asm_d;
                  else if (!we_q) d_rdata_q <= asm_d;
               end else begin
                  cnt_q       <= cnt_d;
                  mem_addr_q  <= base_q + ADDR_W'(cnt_d);
                  mem_wdata_q <= we_q ? pick(wdata_q, cnt_d, word_q) : 8'h00;
               end
            end
            RESP: begin
               state_q   <= IDLE;
               if_done_q <= 1'b0;
               d_done_q  <= 1'b0;
               busy_q    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_data   = if_data_q;
   assign if_done   = if_done_q;
   assign PCWrite   = if_done_q;
   assign d_rdata   = d_rdata_q;
   assign d_done    = d_done_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a 256-byte memory model.
module tb_mem_port_arbiter;
   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_size = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic [31:0] if_data, d_rdata, mem_addr;
   logic        if_done, d_done, mem_en, mem_we, PCWrite, busy;
   logic [7:0]  mem_wdata, mem_rdata;
   logic [7:0]  mem [256];
   int          tests = 0, fails = 0;

   mem_port_arbiter #(.ADDR_W(32)) dut (
      .Clk(Clk), .Reset(Reset),
      .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .PCWrite(PCWrite), .busy(busy)
   );

   always #5 Clk = ~Clk;
   assign mem_rdata = mem[mem_addr[7:0]];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"}, 32'(mem_en), 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, {30'b0, if_done, d_done}, 0);
   endtask

   initial begin
      logic [31:0] words [4];
      logic [7:0]  sw_bytes [4];
      logic        exp_fetch;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
      {mem[0], mem[1], mem[2], mem[3]}         = 32'h2401002C;
      mem[8'h50]                                = 8'hF0;
      {mem[8'hFE], mem[8'hFF]}                  = 16'hDEAD;
      {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} = 32'h87654321;
      sw_bytes = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};

      // reset state
      tick(); tick();
      Reset = 1'b1;
      chk_idle("rst");
      chk("rst_if_data", if_data, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_pcw", 32'(PCWrite), 0);

      // reset during beat 2 of a word store
      d_req = 1; d_we = 1; d_size = 1; d_addr = 32'h40; d_wdata = 32'h11223344;
      tick();
      d_req = 0;
      chk("sw0_addr", mem_addr, 32'h40);
      chk("sw0_wdata", 32'(mem_wdata), 32'h11);
      chk("sw0_we", 32'(mem_we), 1);
      tick(); tick();
      chk("sw2_addr", mem_addr, 32'h42);
      chk("sw2_wdata", 32'(mem_wdata), 32'h33);
      Reset = 0;
      tick();
      chk_idle("abort");
      Reset = 1;
      tick(); tick();
      chk_idle("abort_after");

      // word fetch from 0
      if_req = 1; if_addr = 32'h0;
      tick();
      if_req = 0;
      for (int k = 0; k < 4; k++) begin
         chk("if_addr", mem_addr, 32'(k));
         chk("if_en", 32'(mem_en), 1);
         chk("if_we", 32'(mem_we), 0);
         chk("if_pcw_early", 32'(PCWrite), 0);
         tick();
      end
      chk("if_data", if_data, 32'h2401002C);
      chk("if_done", 32'(if_done), 1);
      chk("if_pcw", 32'(PCWrite), 1);
      chk("if_busy", 32'(busy), 1);
      tick();
      chk("if_done_off", 32'(if_done), 0);
      chk("if_pcw_off", 32'(PCWrite), 0);
      chk("if_data_hold", if_data, 32'h2401002C);
      chk("if_idle_busy", 32'(busy), 0);

      // byte store
      d_req = 1; d_we = 1; d_size = 0; d_addr = 32'h21; d_wdata = 32'hA5A5A5C3;
      tick();
      d_req = 0;
      chk("sb_addr", mem_addr, 32'h21);
      chk("sb_we", 32'(mem_we), 1);
      chk("sb_wdata", 32'(mem_wdata), 32'hC3);
      tick();
      chk("sb_done", 32'(d_done), 1);
      chk("sb_en_off", 32'(mem_en), 0);
      chk("sb_rdata_kept", d_rdata, 0);
      tick();
      chk_idle("sb_idle");

      // byte load zero-extended
      d_req = 1; d_we = 0; d_size = 0; d_addr = 32'h50;
      tick();
      d_req = 0;
      chk("lb_addr", mem_addr, 32'h50);
      chk("lb_we", 32'(mem_we), 0);
      tick();
      chk("lb_done", 32'(d_done), 1);
      chk("lb_rdata", d_rdata, 32'h000000F0);
      tick();

      // word load wrapping past the top of the address space
      d_req = 1; d_size = 1; d_addr = 32'hFFFFFFFE;
      tick();
      d_req = 0;
      words = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
      for (int k = 0; k < 4; k++) begin
         chk("lw_wrap_addr", mem_addr, words[k]);
         tick();
      end
      chk("lw_done", 32'(d_done), 1);
      chk("lw_pcw", 32'(PCWrite), 0);
      chk("lw_rdata", d_rdata, 32'hDEAD2401);
      chk("lw_if_data_kept", if_data, 32'h2401002C);
      tick();

      // both requests held: last completion was data, so fetch goes first, then alternation
      if_req = 1; if_addr = 32'h0;
      d_req = 1; d_we = 0; d_size = 1; d_addr = 32'h10;
      exp_fetch = 1;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("alt_base", mem_addr, exp_fetch ? 32'h0 : 32'h10);
         tick(); tick(); tick(); tick();
         chk("alt_ifdone", 32'(if_done), 32'(exp_fetch));
         chk("alt_pcw", 32'(PCWrite), 32'(exp_fetch));
         chk("alt_ddone", 32'(d_done), 32'(!exp_fetch));
         if (exp_fetch) chk("alt_if_data", if_data, 32'h2401002C);
         else chk("alt_d_rdata", d_rdata, 32'h87654321);
         tick();
         chk("alt_idle", 32'(busy), 0);
         exp_fetch = !exp_fetch;
      end
      if_req = 0; d_req = 0;
      tick(); tick();

      // store with request dropped and address/data changed after grant
      d_req = 1; d_we = 1; d_size = 1; d_addr = 32'h80; d_wdata = 32'hCAFEBABE;
      tick();
      d_req = 0; d_addr = 32'h90; d_wdata = 32'h0; d_size = 0;
      for (int k = 0; k < 4; k++) begin
         chk("swl_addr", mem_addr, 32'h80 + 32'(k));
         chk("swl_wdata", 32'(mem_wdata), 32'(sw_bytes[k]));
         chk("swl_we", 32'(mem_we), 1);
         tick();
      end
      chk("swl_done", 32'(d_done), 1);
      chk("swl_rdata_kept", d_rdata, 32'h87654321);
      tick();
      tick();
      chk_idle("swl_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
